uart_rx: RTL and testbench

- Serial receiver for UART1; consumes the `serial_out` line of the UART1 transmitter.
- Recovers 8-bit frames (start bit, 8 data bits LSB first, stop bit) and presents each byte on a valid/ready interface to the downstream consumer.
- Detects framing errors and overrun.
- Single clock domain, shared with the transmitter. The input passes through a synchroniser so an asynchronous line can also be used.

---
 rtl/uart_rx.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) with a
// valid/ready byte output and framing/overrun (and optional parity) error pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int            H        = (CLKS_PER_BIT - 1) / 2;
    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(H);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam state_t AFTER_DATA = S_STOP;
`endif

    logic rx_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rx_s = rx_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            // Input synchroniser chain; resets to the idle (high) line level.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '1;
                end else begin
                    sync_q[0] <= rx_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign rx_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          deliver_s;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_err_q, parity_err_d;
`endif

    // State, bit timing and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    // Frame FSM: next state, bit sampling, delivery and handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        deliver_s   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    bit_d = 3'd0;
                    // With H = 0 the edge itself is the start-bit centre.
                    if (H == 0) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_START;
                        cnt_d   = CW'(1);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = AFTER_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        deliver_s = 1'b1;
                        state_d   = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        parity_err_d = ^{shift_q, par_q};
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_BREAK;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A delivery always wins over a simultaneous acceptance.
        if (deliver_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q & ~rx_ready;
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clock/bit, one at 16 clocks/bit.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int PB = PAR_EN ? 1 : 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx1 = 1'b1, rx16 = 1'b1;
    logic       ready1 = 1'b0, ready16 = 1'b0;
    logic [7:0] rx_data1, rx_data16;
    logic       rx_valid1, rx_valid16, busy1, busy16;
    logic       frame_err1, frame_err16, overrun1, overrun16, parity_err1, parity_err16;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int rise1 = 0, rise16 = 0, rise1_cyc = 0, rise16_cyc = 0;
    int fe1 = 0, fe16 = 0, ov1 = 0, ov16 = 0, pe1 = 0, pe16 = 0;
    logic v1_prev = 1'b0, v16_prev = 1'b0;
    logic [7:0] last1 = 8'h00, prev1 = 8'h00;

    uart_rx #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .rx_in(rx1), .rx_ready(ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1),
        .frame_err(frame_err1), .overrun(overrun1), .parity_err(parity_err1)
    );

    uart_rx #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .rst(rst), .rx_in(rx16), .rx_ready(ready16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .busy(busy16),
        .frame_err(frame_err16), .overrun(overrun16), .parity_err(parity_err16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: rx_valid rises and error pulse counts, sampled mid-cycle.
    always @(negedge clk) begin
        v1_prev  <= rx_valid1;
        v16_prev <= rx_valid16;
        if (rx_valid1 && !v1_prev) begin
            rise1     <= rise1 + 1;
            rise1_cyc <= cyc;
            prev1     <= last1;
            last1     <= rx_data1;
        end
        if (rx_valid16 && !v16_prev) begin
            rise16     <= rise16 + 1;
            rise16_cyc <= cyc;
        end
        if (frame_err1)   fe1  <= fe1 + 1;
        if (frame_err16)  fe16 <= fe16 + 1;
        if (overrun1)     ov1  <= ov1 + 1;
        if (overrun16)    ov16 <= ov16 + 1;
        if (parity_err1)  pe1  <= pe1 + 1;
        if (parity_err16) pe16 <= pe16 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) rx16 = v;
        else     rx1  = v;
        wait_clks(n);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic stop_v, input logic bad_par);
        int n;
        n = sel ? 16 : 1;
        drive(sel, 1'b0, n);
        for (int i = 0; i < 8; i++) drive(sel, d[i], n);
        if (PAR_EN) drive(sel, (^d) ^ bad_par, n);
        drive(sel, stop_v, n);
    endtask

    initial begin
        int n0, r0, f0, o0, p0;

        // Reset state
        wait_clks(3);
        check_eq("rst_data16", 32'(rx_data16), 32'h00);
        check_eq("rst_valid16", 32'(rx_valid16), 32'h0);
        check_eq("rst_busy16", 32'(busy16), 32'h0);
        check_eq("rst_valid1", 32'(rx_valid1), 32'h0);
        check_eq("rst_pulses", 32'({frame_err1, overrun1, parity_err1, frame_err16, overrun16, parity_err16}), 32'h0);
        rst = 1'b1;
        wait_clks(3);

        // 0xBA at 1 clk/bit, ready high: one-cycle valid, fixed latency
        ready1 = 1'b1;
        r0 = rise1;
        n0 = cyc;
        send(1'b0, 8'hBA, 1'b1, 1'b0);
        wait_clks(10);
        check_eq("t1_rises", 32'(rise1 - r0), 32'd1);
        check_eq("t1_latency", 32'(rise1_cyc - n0), 32'(12 + PB));
        check_eq("t1_data", 32'(rx_data1), 32'hBA);
        check_eq("t1_valid_low", 32'(rx_valid1), 32'h0);
        check_eq("t1_errs", 32'(fe1 + ov1), 32'd0);

        // Back-to-back frames at 1 clk/bit
        r0 = rise1;
        send(1'b0, 8'h3C, 1'b1, 1'b0);
        send(1'b0, 8'hC3, 1'b1, 1'b0);
        wait_clks(10);
        check_eq("b2b_rises", 32'(rise1 - r0), 32'd2);
        check_eq("b2b_first", 32'(prev1), 32'h3C);
        check_eq("b2b_second", 32'(last1), 32'hC3);

        // 16 clk/bit, ready low: second frame overruns the first
        ready16 = 1'b0;
        r0 = rise16;
        o0 = ov16;
        n0 = cyc;
        send(1'b1, 8'h55, 1'b1, 1'b0);
        wait_clks(2);
        check_eq("t2_latency", 32'(rise16_cyc - n0), 32'(154 + 16 * PB));
        check_eq("t2_valid1", 32'(rx_valid16), 32'h1);
        check_eq("t2_data1", 32'(rx_data16), 32'h55);
        check_eq("t2_no_ovr", 32'(ov16 - o0), 32'd0);
        send(1'b1, 8'hA3, 1'b1, 1'b0);
        wait_clks(2);
        check_eq("t2_ovr", 32'(ov16 - o0), 32'd1);
        check_eq("t2_data2", 32'(rx_data16), 32'hA3);
        check_eq("t2_valid2", 32'(rx_valid16), 32'h1);
        check_eq("t2_one_rise", 32'(rise16 - r0), 32'd1);
        ready16 = 1'b1;
        check_eq("t2_hs_clk", 32'(rx_valid16), 32'h1);
        wait_clks(1);
        check_eq("t2_valid_fell", 32'(rx_valid16), 32'h0);
        check_eq("t2_data_kept", 32'(rx_data16), 32'hA3);

        // Framing error with the line held low afterwards
        r0 = rise16;
        f0 = fe16;
        send(1'b1, 8'h96, 1'b0, 1'b0);
        wait_clks(40);
        check_eq("t3_fe_once", 32'(fe16 - f0), 32'd1);
        check_eq("t3_busy_break", 32'(busy16), 32'h1);
        rx16 = 1'b1;
        wait_clks(30);
        check_eq("t3_idle", 32'(busy16), 32'h0);
        check_eq("t3_fe_total", 32'(fe16 - f0), 32'd1);
        check_eq("t3_no_delivery", 32'(rise16 - r0), 32'd0);
        check_eq("t3_valid", 32'(rx_valid16), 32'h0);

        // 4-clock glitch on an idle line
        r0 = rise16;
        f0 = fe16;
        o0 = ov16;
        n0 = cyc;
        rx16 = 1'b0;
        wait_clks(4);
        rx16 = 1'b1;
        wait_clks(1);
        check_eq("t4_busy_hi", 32'(busy16), 32'h1);
        check_eq("t4_cyc", 32'(cyc - n0), 32'd5);
        wait_clks(7);
        check_eq("t4_busy_lo", 32'(busy16), 32'h0);
        wait_clks(200);
        check_eq("t4_no_pulses", 32'((rise16 - r0) + (fe16 - f0) + (ov16 - o0)), 32'd0);

        // Reset in the middle of data bit 4, then a clean 0x0F frame
        ready16 = 1'b0;
        drive(1'b1, 1'b0, 16);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16);
        drive(1'b1, 1'b0, 8);
        rst = 1'b0;
        rx16 = 1'b1;
        wait_clks(3);
        check_eq("t5_rst_valid", 32'(rx_valid16), 32'h0);
        check_eq("t5_rst_busy", 32'(busy16), 32'h0);
        check_eq("t5_rst_data", 32'(rx_data16), 32'h00);
        rst = 1'b1;
        wait_clks(5);
        r0 = rise16;
        send(1'b1, 8'h0F, 1'b1, 1'b0);
        wait_clks(10);
        check_eq("t5_rises", 32'(rise16 - r0), 32'd1);
        check_eq("t5_data", 32'(rx_data16), 32'h0F);
        check_eq("t5_valid", 32'(rx_valid16), 32'h1);
        ready16 = 1'b1;
        wait_clks(3);

        // Parity: 0x07 needs parity bit 1 for even parity
        p0 = pe1;
        r0 = rise1;
        send(1'b0, 8'h07, 1'b1, 1'b1);
        wait_clks(10);
        check_eq("t6_data", 32'(last1), 32'h07);
        check_eq("t6_delivered", 32'(rise1 - r0), 32'd1);
`ifdef UART_RX_PARITY_EN
        check_eq("t6_perr", 32'(pe1 - p0), 32'd1);
        p0 = pe1;
        send(1'b0, 8'h07, 1'b1, 1'b0);
        wait_clks(10);
        check_eq("t6_no_perr", 32'(pe1 - p0), 32'd0);
        check_eq("t6_data_ok", 32'(last1), 32'h07);
`else
        check_eq("t6_perr_tied", 32'(pe1 + pe16), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
